// File: rtl/cu_pkg.sv
// Shared types and constants for the multi-cycle LEGv8 control unit:
// state and instruction-class enums, opcode match patterns and ALUOp codes.
package cu_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } cu_state_t;

  typedef enum logic [2:0] {
    CL_RFMT    = 3'd0,
    CL_LDUR    = 3'd1,
    CL_STUR    = 3'd2,
    CL_CBZ     = 3'd3,
    CL_CBNZ    = 3'd4,
    CL_B       = 3'd5,
    CL_ILLEGAL = 3'd6
  } inst_class_t;

  localparam int DEC_W = 11;

  // Mask bits set to 1 are compared; 0 bits are don't-care opcode fields.
  localparam logic [DEC_W-1:0] RFMT_MASK = 11'b10011110111;
  localparam logic [DEC_W-1:0] RFMT_VAL  = 11'b10001010000;
  localparam logic [DEC_W-1:0] LDUR_MASK = 11'b11111111111;
  localparam logic [DEC_W-1:0] LDUR_VAL  = 11'b11111000010;
  localparam logic [DEC_W-1:0] STUR_MASK = 11'b11111111111;
  localparam logic [DEC_W-1:0] STUR_VAL  = 11'b11111000000;
  localparam logic [DEC_W-1:0] CBZ_MASK  = 11'b11111111000;
  localparam logic [DEC_W-1:0] CBZ_VAL   = 11'b10110100000;
  localparam logic [DEC_W-1:0] CBNZ_MASK = 11'b11111111000;
  localparam logic [DEC_W-1:0] CBNZ_VAL  = 11'b10110101000;
  localparam logic [DEC_W-1:0] B_MASK    = 11'b11111100000;
  localparam logic [DEC_W-1:0] B_VAL     = 11'b00010100000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RFMT  = 2'b10;

  function automatic logic op_match(input logic [DEC_W-1:0] op,
                                    input logic [DEC_W-1:0] mask,
                                    input logic [DEC_W-1:0] val);
    return (op & mask) == val;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_decode.sv
// Combinational opcode classifier (cu_decode); only the top 11 opcode bits matter.
// CBNZ and B are recognised only when CU_CBNZ_B_EN is defined.
module cu_decode
  import cu_pkg::*;
#(
  parameter int OPCODE_W = 11
) (
  input  logic [OPCODE_W-1:0] opcode,
  output inst_class_t         cls
);

  logic [DEC_W-1:0] op;

  assign op = opcode[OPCODE_W-1 -: DEC_W];

  always_comb begin
    cls = CL_ILLEGAL;
    if (op_match(op, RFMT_MASK, RFMT_VAL))
      cls = CL_RFMT;
    else if (op_match(op, LDUR_MASK, LDUR_VAL))
      cls = CL_LDUR;
    else if (op_match(op, STUR_MASK, STUR_VAL))
      cls = CL_STUR;
    else if (op_match(op, CBZ_MASK, CBZ_VAL))
      cls = CL_CBZ;
`ifdef CU_CBNZ_B_EN
    else if (op_match(op, CBNZ_MASK, CBNZ_VAL))
      cls = CL_CBNZ;
    else if (op_match(op, B_MASK, B_VAL))
      cls = CL_B;
`endif
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle LEGv8 control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a
// memory-wait timeout and illegal-opcode trap. Define CU_CBNZ_B_EN for CBNZ and B.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int OPCODE_W     = 11,
  parameter int ALUOP_W      = 2,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                Reg2Loc,
  output logic                ALUSrc,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                Branch,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                UncondBranch,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                illegal,
  output logic                timeout,
  output logic [2:0]          state
);

  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_WAIT_MAX);

  cu_state_t        cur;
  inst_class_t      cls_q;
  inst_class_t      dec_cls;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_inc;
  logic             wait_hit;

  cu_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .opcode (opcode),
    .cls    (dec_cls)
  );

  assign state    = cur;
  assign wait_inc = wait_cnt + CNT_W'(1);
  // A ready memory on the limit cycle takes priority over the timeout.
  assign wait_hit = !mem_ready && (wait_inc == WAIT_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= ST_RESET;
      cls_q    <= CL_RFMT;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (cur)
        ST_RESET: begin
          cur      <= ST_FETCH;
          wait_cnt <= '0;
        end
        ST_FETCH: begin
          if (mem_ready) begin
            cur <= ST_DECODE;
          end else begin
            wait_cnt <= wait_inc;
            if (wait_hit) begin
              cur     <= ST_TRAP;
              timeout <= 1'b1;
            end
          end
        end
        ST_DECODE: begin
          cls_q <= dec_cls;
          if (dec_cls == CL_ILLEGAL) begin
            cur     <= ST_TRAP;
            illegal <= 1'b1;
          end else begin
            cur <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          wait_cnt <= '0;
          case (cls_q)
            CL_RFMT:          cur <= ST_WB;
            CL_LDUR, CL_STUR: cur <= ST_MEM;
            default:          cur <= ST_FETCH;
          endcase
        end
        ST_MEM: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            cur      <= (cls_q == CL_LDUR) ? ST_WB : ST_FETCH;
          end else begin
            wait_cnt <= wait_inc;
            if (wait_hit) begin
              cur     <= ST_TRAP;
              timeout <= 1'b1;
            end
          end
        end
        ST_WB: begin
          wait_cnt <= '0;
          cur      <= ST_FETCH;
        end
        ST_TRAP: cur <= ST_TRAP;
        default: cur <= ST_TRAP;
      endcase
    end
  end

  // Moore decode of the datapath controls; FETCH and CBZ/CBNZ also gate on ready/zero.
  always_comb begin
    Reg2Loc      = 1'b0;
    ALUSrc       = 1'b0;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    Branch       = 1'b0;
    ALUOp        = '0;
    UncondBranch = 1'b0;
    PCWrite      = 1'b0;
    IRWrite      = 1'b0;
    case (cur)
      ST_FETCH: begin
        MemRead = 1'b1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      ST_EXEC: begin
        case (cls_q)
          CL_RFMT: ALUOp = ALUOP_W'(ALUOP_RFMT);
          CL_LDUR: begin
            ALUSrc = 1'b1;
            ALUOp  = ALUOP_W'(ALUOP_ADD);
          end
          CL_STUR: begin
            ALUSrc  = 1'b1;
            Reg2Loc = 1'b1;
            ALUOp   = ALUOP_W'(ALUOP_ADD);
          end
          CL_CBZ, CL_CBNZ: begin
            Reg2Loc = 1'b1;
            ALUOp   = ALUOP_W'(ALUOP_PASSB);
            Branch  = 1'b1;
            PCWrite = (cls_q == CL_CBZ) ? zero : ~zero;
          end
          CL_B: begin
            UncondBranch = 1'b1;
            PCWrite      = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        ALUSrc = 1'b1;
        if (cls_q == CL_LDUR) begin
          MemRead = 1'b1;
        end else begin
          MemWrite = 1'b1;
          Reg2Loc  = 1'b1;
        end
      end
      ST_WB: begin
        RegWrite = 1'b1;
        MemtoReg = (cls_q == CL_LDUR);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: builds expected per-cycle
// traces from the instruction-level rules and compares every cycle.
module tb_multicycle_control_unit;

  localparam logic [2:0] S_RESET = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;
  localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CBZ = 3, C_CBNZ = 4, C_B = 5, C_ILL = 6;
  localparam int MAXW = 15;

  logic        clk, rst_n, zero, mem_ready;
  logic [10:0] opcode;
  logic        Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
  logic [1:0]  ALUOp;
  logic        UncondBranch, PCWrite, IRWrite, illegal, timeout;
  logic [2:0]  state;
  logic [16:0] obs;

  // Control vector order: {Reg2Loc,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,UncondBranch,PCWrite,IRWrite}
  typedef struct packed {
    logic        mr;
    logic        z;
    logic [10:0] op;
    logic [16:0] exp;
  } cyc_t;

  cyc_t trace[$];
  int   checks = 0;
  int   failures = 0;

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp),
    .UncondBranch(UncondBranch), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .illegal(illegal), .timeout(timeout), .state(state)
  );

  assign obs = {state, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
                UncondBranch, PCWrite, IRWrite, ALUOp, illegal, timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int classify(input logic [10:0] op);
    if (op ==? 11'b1??0101?000) return C_R;
    if (op == 11'b11111000010) return C_LD;
    if (op == 11'b11111000000) return C_ST;
    if (op ==? 11'b10110100???) return C_CBZ;
`ifdef CU_CBNZ_B_EN
    if (op ==? 11'b10110101???) return C_CBNZ;
    if (op ==? 11'b000101?????) return C_B;
`endif
    return C_ILL;
  endfunction

  function automatic logic [10:0] rand_op(input int c);
    logic [10:0] r;
    r = 11'($urandom);
    case (c)
      C_R:     return 11'b10001010000 | (r & 11'b01100001000);
      C_LD:    return 11'b11111000010;
      C_ST:    return 11'b11111000000;
      C_CBZ:   return 11'b10110100000 | (r & 11'b00000000111);
      C_CBNZ:  return 11'b10110101000 | (r & 11'b00000000111);
      C_B:     return 11'b00010100000 | (r & 11'b00000011111);
      default: return 11'b00000000000;
    endcase
  endfunction

  task automatic add(input logic [2:0] st, input logic [9:0] ctl, input logic [1:0] aop,
                     input logic ill, input logic to, input logic mr, input logic z,
                     input logic [10:0] op);
    cyc_t c;
    c.mr  = mr;
    c.z   = z;
    c.op  = op;
    c.exp = {st, ctl, aop, ill, to};
    trace.push_back(c);
  endtask

  // Expected cycles of one instruction; a negative wait means memory never answers.
  task automatic build_trace(input logic [10:0] op, input int fw, input int mw, input logic zv);
    int   c, n;
    logic r;
    c = classify(op);
    n = (fw < 0) ? MAXW : fw + 1;
    for (int i = 0; i < n; i++) begin
      r = (fw >= 0) && (i == fw);
      add(S_FETCH, {4'b0000, 1'b1, 3'b000, r, r}, 2'b00, 1'b0, 1'b0, r, rb(), op);
    end
    if (fw < 0) return;
    add(S_DECODE, 10'b0, 2'b00, 1'b0, 1'b0, rb(), rb(), op);
    case (c)
      C_R:    add(S_EXEC, 10'b0000000000, 2'b10, 1'b0, 1'b0, rb(), rb(), op);
      C_LD:   add(S_EXEC, 10'b0100000000, 2'b00, 1'b0, 1'b0, rb(), rb(), op);
      C_ST:   add(S_EXEC, 10'b1100000000, 2'b00, 1'b0, 1'b0, rb(), rb(), op);
      C_CBZ:  add(S_EXEC, {7'b1000001, 1'b0, zv, 1'b0}, 2'b01, 1'b0, 1'b0, rb(), zv, op);
      C_CBNZ: add(S_EXEC, {7'b1000001, 1'b0, ~zv, 1'b0}, 2'b01, 1'b0, 1'b0, rb(), zv, op);
      C_B:    add(S_EXEC, 10'b0000000110, 2'b00, 1'b0, 1'b0, rb(), zv, op);
      default: return;
    endcase
    if (c == C_LD || c == C_ST) begin
      n = (mw < 0) ? MAXW : mw + 1;
      for (int i = 0; i < n; i++) begin
        r = (mw >= 0) && (i == mw);
        add(S_MEM, (c == C_LD) ? 10'b0100100000 : 10'b1100010000, 2'b00, 1'b0, 1'b0, r, rb(), op);
      end
      if (mw < 0) return;
    end
    if (c == C_R)  add(S_WB, 10'b0001000000, 2'b00, 1'b0, 1'b0, rb(), rb(), op);
    if (c == C_LD) add(S_WB, 10'b0011000000, 2'b00, 1'b0, 1'b0, rb(), rb(), op);
  endtask

  task automatic add_trap(input int cnt, input logic ill, input logic to);
    for (int i = 0; i < cnt; i++)
      add(S_TRAP, 10'b0, 2'b00, ill, to, rb(), rb(), 11'($urandom));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [16:0] e;
    rst_n = 1'b1;
    mem_ready = 1'b0;
    zero = 1'b0;
    opcode = 11'b0;
    #1 rst_n = 1'b0;
    #1;
    e = {S_RESET, 14'b0};
    checks++;
    if (obs !== e) begin
      failures++;
      $display("[TB] FAIL reset_assert: got %h want %h", obs, e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== e) begin
      failures++;
      $display("[TB] FAIL reset_hold_one_cycle: got %h want %h", obs, e);
    end
    @(posedge clk);
    #1;
    e = {S_FETCH, 10'b0000100000, 4'b0};
    checks++;
    if (obs !== e) begin
      failures++;
      $display("[TB] FAIL reset_to_fetch: got %h want %h", obs, e);
    end
  endtask

  task automatic test_rformat();
    do_reset();
    build_trace(11'b10001011000, 0, 0, 1'b0);
    add(S_FETCH, 10'b0000100011, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 11'b10001011000);
    foreach (trace[i]) begin
      mem_ready = trace[i].mr; zero = trace[i].z; opcode = trace[i].op;
      #1;
      checks++;
      if (obs !== trace[i].exp) begin
        failures++;
        $display("[TB] FAIL rformat cyc%0d: got %h want %h", i, obs, trace[i].exp);
      end
      @(posedge clk); #1;
    end
    trace.delete();
  endtask

  task automatic test_ldur_wait();
    do_reset();
    build_trace(11'b11111000010, 0, 3, 1'b0);
    foreach (trace[i]) begin
      mem_ready = trace[i].mr; zero = trace[i].z; opcode = trace[i].op;
      #1;
      checks++;
      if (obs !== trace[i].exp) begin
        failures++;
        $display("[TB] FAIL ldur_wait cyc%0d: got %h want %h", i, obs, trace[i].exp);
      end
      @(posedge clk); #1;
    end
    trace.delete();
  endtask

  task automatic test_cbz();
    do_reset();
    build_trace(11'b10110100101, 0, 0, 1'b1);
    build_trace(11'b10110100101, 1, 0, 1'b0);
    build_trace(11'b10110100011, 0, 0, 1'b1);
    foreach (trace[i]) begin
      mem_ready = trace[i].mr; zero = trace[i].z; opcode = trace[i].op;
      #1;
      checks++;
      if (obs !== trace[i].exp) begin
        failures++;
        $display("[TB] FAIL cbz cyc%0d: got %h want %h", i, obs, trace[i].exp);
      end
      @(posedge clk); #1;
    end
    trace.delete();
  endtask

  task automatic test_random();
    int ncls;
`ifdef CU_CBNZ_B_EN
    ncls = 6;
`else
    ncls = 4;
`endif
    do_reset();
    for (int k = 0; k < 30; k++)
      build_trace(rand_op($urandom_range(0, ncls - 1)), $urandom_range(0, 3),
                  $urandom_range(0, 3), rb());
    foreach (trace[i]) begin
      mem_ready = trace[i].mr; zero = trace[i].z; opcode = trace[i].op;
      #1;
      checks++;
      if (obs !== trace[i].exp) begin
        failures++;
        $display("[TB] FAIL random cyc%0d op=%b: got %h want %h", i, trace[i].op, obs, trace[i].exp);
      end
      @(posedge clk); #1;
    end
    trace.delete();
  endtask

  task automatic test_illegal();
    logic [16:0] e;
    do_reset();
    build_trace(11'b00000000000, 0, 0, 1'b0);
    add_trap(20, 1'b1, 1'b0);
    foreach (trace[i]) begin
      mem_ready = trace[i].mr; zero = trace[i].z; opcode = trace[i].op;
      #1;
      checks++;
      if (obs !== trace[i].exp) begin
        failures++;
        $display("[TB] FAIL illegal cyc%0d: got %h want %h", i, obs, trace[i].exp);
      end
      @(posedge clk); #1;
    end
    trace.delete();
    rst_n = 1'b0;
    #1;
    e = {S_RESET, 14'b0};
    checks++;
    if (obs !== e) begin
      failures++;
      $display("[TB] FAIL illegal_cleared_by_reset: got %h want %h", obs, e);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    build_trace(11'b10001010000, -1, 0, 1'b0);
    add_trap(5, 1'b0, 1'b1);
    foreach (trace[i]) begin
      mem_ready = trace[i].mr; zero = trace[i].z; opcode = trace[i].op;
      #1;
      checks++;
      if (obs !== trace[i].exp) begin
        failures++;
        $display("[TB] FAIL fetch_timeout cyc%0d: got %h want %h", i, obs, trace[i].exp);
      end
      @(posedge clk); #1;
    end
    trace.delete();
    // Ready on the limit cycle, then a store whose memory never answers.
    do_reset();
    build_trace(11'b10001010000, MAXW - 1, 0, 1'b0);
    build_trace(11'b11111000010, 0, MAXW - 1, 1'b0);
    build_trace(11'b11111000000, 10, -1, 1'b0);
    add_trap(3, 1'b0, 1'b1);
    foreach (trace[i]) begin
      mem_ready = trace[i].mr; zero = trace[i].z; opcode = trace[i].op;
      #1;
      checks++;
      if (obs !== trace[i].exp) begin
        failures++;
        $display("[TB] FAIL wait_limit cyc%0d: got %h want %h", i, obs, trace[i].exp);
      end
      @(posedge clk); #1;
    end
    trace.delete();
  endtask

  task automatic test_branch_b();
    do_reset();
    build_trace(11'b00010100000, 0, 0, 1'b0);
`ifdef CU_CBNZ_B_EN
    build_trace(11'b10110101111, 0, 0, 1'b0);
    build_trace(11'b10110101001, 0, 0, 1'b1);
`else
    add_trap(5, 1'b1, 1'b0);
`endif
    foreach (trace[i]) begin
      mem_ready = trace[i].mr; zero = trace[i].z; opcode = trace[i].op;
      #1;
      checks++;
      if (obs !== trace[i].exp) begin
        failures++;
        $display("[TB] FAIL branch_b cyc%0d: got %h want %h", i, obs, trace[i].exp);
      end
      @(posedge clk); #1;
    end
    trace.delete();
  endtask

  task automatic test_mid_reset();
    logic [16:0] e;
    do_reset();
    opcode = 11'b11111000000;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    e = {S_MEM, 10'b1100010000, 4'b0};
    checks++;
    if (obs !== e) begin
      failures++;
      $display("[TB] FAIL mid_reset_in_mem: got %h want %h", obs, e);
    end
    #1 rst_n = 1'b0;
    #1;
    e = {S_RESET, 14'b0};
    checks++;
    if (obs !== e) begin
      failures++;
      $display("[TB] FAIL mid_reset_async: got %h want %h", obs, e);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_rformat();
    test_ldur_wait();
    test_cbz();
    test_random();
    test_illegal();
    test_timeout();
    test_branch_b();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle LEGv8 control unit: a Moore state machine that sequences each instruction through FETCH, DECODE, EXEC, MEM and WB. It generates the classic datapath controls plus PC/IR write enables. It tolerates variable-latency memory through a ready handshake with a timeout, and traps on illegal opcodes. It replaces the single-cycle combinational decoder when the datapath moves to a shared-memory multi-cycle organisation.

## Interface
- OPCODE_W, 11, instruction opcode field width; must be ≥ 11, and only the top 11 bits are decoded.
- ALUOP_W, 2, ALUOp width, minimum 2; encodings are zero-extended.
- MEM_WAIT_MAX, 15, maximum idle-wait cycles per memory access before trap; counter width is $clog2(MEM_WAIT_MAX+1).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  OPCODE_W  opcode from the instruction register; valid from DECODE onward.
- zero  in  1  ALU zero flag, sampled in EXEC.
- mem_ready  in  1  memory completes the current access this cycle.
- Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch  out  1 each  datapath controls.
- ALUOp  out  ALUOP_W  00 = add, 01 = pass B (compare), 10 = R-format function field.
- UncondBranch, PCWrite, IRWrite  out  1 each  unconditional branch select, PC write enable, IR write enable.
- illegal  out  1  sticky; set on an undecodable opcode.
- timeout  out  1  sticky; set when a memory wait reaches the limit.
- state  out  3  current state, for debug.

## Operation
- Opcode classes:
  - R-format: 1xx0101x000
  - LDUR: 11111000010
  - STUR: 11111000000
  - CBZ: 10110100xxx
  - Anything else is ILLEGAL, subject to Configuration.
- The class is latched in DECODE and held until the next DECODE.
- States: RESET, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Transitions:
  - RESET→FETCH.
  - FETCH→DECODE on mem_ready.
  - DECODE→EXEC, or DECODE→TRAP if ILLEGAL.
  - EXEC→WB for R-format, EXEC→MEM for LDUR/STUR, EXEC→FETCH for CBZ/B.
  - MEM→WB for LDUR on mem_ready; MEM→FETCH for STUR on mem_ready.
  - WB→FETCH.
  - TRAP is absorbing until reset.
- Outputs are combinational from the state register and latched class. Every signal not listed for a state is driven 0, never x.
- Outputs by state:
  - FETCH: MemRead=1; IRWrite=PCWrite=mem_ready (PC+4).
  - DECODE: none.
  - EXEC R-format: ALUOp=10.
  - EXEC LDUR: ALUSrc=1, ALUOp=00.
  - EXEC STUR: ALUSrc=1, Reg2Loc=1, ALUOp=00.
  - EXEC CBZ: Reg2Loc=1, ALUOp=01, Branch=1, PCWrite=zero.
  - MEM LDUR: MemRead=1, ALUSrc=1.
  - MEM STUR: MemWrite=1, ALUSrc=1, Reg2Loc=1.
  - WB: RegWrite=1; MemtoReg=1 for LDUR, 0 for R-format.
- Wait counter:
  - Cleared on entry to FETCH and MEM.
  - Increments on each cycle with mem_ready low.
  - Reaching MEM_WAIT_MAX with mem_ready low → TRAP, timeout=1.
  - mem_ready high on the limit cycle wins: normal transition, no trap.
- TRAP: all controls 0, illegal or timeout held.

## Timing
- Reset: state=RESET, all outputs 0, illegal=timeout=0, counter=0, class=R-format.
- Deassertion: RESET for exactly one cycle, then FETCH.
- Minimum latency with zero-wait memory (instruction cycles including FETCH):
  - CBZ/B: 3
  - R-format: 4
  - STUR: 4
  - LDUR: 5
- Each memory wait adds one cycle.
- Reset asserted mid-instruction: immediate return to RESET. No partial PCWrite, RegWrite or MemWrite after the asynchronous assertion.

## Configuration
- CU_CBNZ_B_EN defined:
  - Adds CBNZ (10110101xxx): EXEC same as CBZ but PCWrite=~zero.
  - Adds B (000101xxxxx): EXEC UncondBranch=1, PCWrite=1.
- CU_CBNZ_B_EN undefined: both opcodes decode ILLEGAL → TRAP.

## Structure
- cu_pkg holds the state enum, instruction-class enum, opcode match patterns/masks and ALUOp encoding constants.
- Sub-module cu_decode: purely combinational opcode→class classifier, including the ILLEGAL class and the macro-gated entries.
- The FSM, wait counter and output logic live in multicycle_control_unit.

## Test plan
- Reset released, opcode=R-format 10001011000, mem_ready=1 → states FETCH, DECODE, EXEC (ALUOp=10), WB (RegWrite=1, MemtoReg=0), FETCH; 4 cycles.
- LDUR 11111000010 with mem_ready low for 3 MEM cycles → MEM held 4 cycles with MemRead=1, ALUSrc=1; then WB with MemtoReg=1; total 8 cycles.
- CBZ 10110100101 with zero=1 → EXEC PCWrite=1, Branch=1. Repeated with zero=0 → PCWrite=0; returns to FETCH either way.
- Opcode 00000000000 → DECODE→TRAP, illegal=1, all controls 0 for 20 cycles. rst_n pulse clears it.
- mem_ready held low in FETCH with MEM_WAIT_MAX=15 → TRAP after 15 wait cycles, timeout=1. Variant: mem_ready rises on cycle 15 → DECODE, no trap.
- B 00010100000: with CU_CBNZ_B_EN → UncondBranch=1, PCWrite=1 in EXEC. Without it → illegal=1.
